lmx2492_fifo_spi_master: RTL

LMX2492_FIFO_SPI_MASTER -- requirements
Module: lmx2492_fifo_spi_master

---
 rtl/lmx2492_pkg.sv | 40 ++++
 rtl/lmx2492_sck_gen.sv | 42 ++++
 rtl/lmx2492_fifo_spi_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lmx2492_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lmx2492_pkg : LMX2492 command-frame layout and SPI master FSM codes |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lmx2492_pkg;

  localparam int c_FRAME_W      = 25;
  localparam int c_VALID_BIT    = 24;
  localparam int c_RW_BIT       = 23;
  localparam int c_ADDR_MSB     = 22;
  localparam int c_ADDR_LSB     = 8;
  localparam int c_DATA_MSB     = 7;
  localparam int c_ADDR_W       = 15;
  localparam int c_DATA_W       = 8;
  localparam int c_SHIFT_W      = 24;
  localparam int c_RX_FIRST_BIT = 16;
  localparam int c_LAST_BIT     = 23;

  typedef logic [2:0] state_t;

  localparam state_t c_ST_IDLE  = 3'd0;
  localparam state_t c_ST_POP   = 3'd1;
  localparam state_t c_ST_LATCH = 3'd2;
  localparam state_t c_ST_SETUP = 3'd3;
  localparam state_t c_ST_SHIFT = 3'd4;
  localparam state_t c_ST_HOLD  = 3'd5;
  localparam state_t c_ST_GAP   = 3'd6;

  function automatic logic [c_FRAME_W-1:0] make_frame(
    input logic                valid,
    input logic                rw,
    input logic [c_ADDR_W-1:0] addr,
    input logic [c_DATA_W-1:0] data
  );
    return {valid, rw, addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lmx2492_sck_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lmx2492_sck_gen : SCK half-period divider, low phase first per bit  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lmx2492_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_sck,
  output logic o_fall_stb
);

  localparam int c_PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(CLK_DIV - 1);

  logic [c_PH_W-1:0] r_phase;
  logic              r_sck;
  logic              w_phase_last;

  assign w_phase_last = (r_phase == c_PH_LAST);

  // Held at phase 0 / SCK low while disabled, so every enable starts a clean low phase.
  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      r_phase <= '0;
      r_sck   <= 1'b0;
    end else if (w_phase_last) begin
      r_phase <= '0;
      r_sck   <= ~r_sck;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign o_sck      = r_sck;
  assign o_fall_stb = i_enable & w_phase_last & r_sck;

endmodule
`default_nettype wire

// File: rtl/lmx2492_fifo_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lmx2492_fifo_spi_master : pops 25-bit command words, drives SPI     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lmx2492_fifo_spi_master
  import lmx2492_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                 read_clk,
  input  logic                 sys_rst,
  input  logic                 adsdata_fifo_empty,
  input  logic [c_FRAME_W-1:0] read_data_i,
  output logic                 read_data_en,
  output logic                 spi_csb,
  output logic                 spi_sck,
  output logic                 spi_sdi,
  input  logic                 spi_sdo,
  output logic [c_DATA_W-1:0]  rd_data_o,
  output logic [c_ADDR_W-1:0]  rd_addr_o,
  output logic                 rd_data_valid,
  output logic                 busy
);

  localparam int c_CNT_MAX = (CS_SETUP > CS_GAP) ?
                             ((CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV) :
                             ((CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [4:0]           r_bit_cnt;
  logic [c_SHIFT_W-1:0] r_shift;
  logic                 r_rw;
  logic [c_ADDR_W-1:0]  r_addr;
  logic [c_DATA_W-1:0]  r_rx;
  logic [c_DATA_W-1:0]  r_rd_data;
  logic [c_ADDR_W-1:0]  r_rd_addr;
  logic                 r_rd_valid;

  logic w_shift_en;
  logic w_in_frame;
  logic w_bit_end;
  logic w_last_bit;
  logic w_setup_done;
  logic w_hold_done;
  logic w_gap_done;

  lmx2492_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (read_clk),
    .rst       (sys_rst),
    .i_enable  (w_shift_en),
    .o_sck     (spi_sck),
    .o_fall_stb(w_bit_end)
  );

  assign w_last_bit   = (r_bit_cnt == 5'(c_LAST_BIT));
  assign w_setup_done = (r_cnt == c_CNT_W'(CS_SETUP - 1));
  assign w_hold_done  = (r_cnt == c_CNT_W'(CLK_DIV - 1));
  assign w_gap_done   = (r_cnt == c_CNT_W'(CS_GAP - 1));

  // r_cnt times SETUP/HOLD/GAP and restarts from zero on every state change.
  always_ff @(posedge read_clk) begin
    if (sys_rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (!adsdata_fifo_empty) w_state_nxt = c_ST_POP;
      c_ST_POP:   w_state_nxt = c_ST_LATCH;
      c_ST_LATCH: w_state_nxt = read_data_i[c_VALID_BIT] ? c_ST_SETUP : c_ST_GAP;
      c_ST_SETUP: if (w_setup_done) w_state_nxt = c_ST_SHIFT;
      c_ST_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:  if (w_hold_done) w_state_nxt = c_ST_GAP;
      c_ST_GAP:   if (w_gap_done) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    read_data_en = (r_state == c_ST_POP);
    busy         = (r_state != c_ST_IDLE);
    w_shift_en   = (r_state == c_ST_SHIFT);
    w_in_frame   = (r_state == c_ST_SETUP) || (r_state == c_ST_SHIFT) || (r_state == c_ST_HOLD);
    spi_csb      = ~w_in_frame;
    spi_sdi      = w_in_frame & r_shift[c_SHIFT_W-1];
  end

  // Shifting on the bit-end strobe moves SDI exactly as SCK drops into the next low phase.
  always_ff @(posedge read_clk) begin
    if (sys_rst) begin
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_rd_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == c_ST_LATCH) begin
        r_shift <= read_data_i[c_SHIFT_W-1:0];
        r_rw    <= read_data_i[c_RW_BIT];
        r_addr  <= read_data_i[c_ADDR_MSB:c_ADDR_LSB];
      end
      if (w_shift_en) begin
        if (w_bit_end) begin
          r_shift <= {r_shift[c_SHIFT_W-2:0], 1'b0};
          if (r_bit_cnt >= 5'(c_RX_FIRST_BIT)) r_rx <= {r_rx[c_DATA_W-2:0], spi_sdo};
          if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_bit_cnt <= '0;
      end
      if ((r_state == c_ST_HOLD) && w_hold_done && r_rw) begin
        r_rd_data  <= r_rx;
        r_rd_addr  <= r_addr;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign rd_data_o     = r_rd_data;
  assign rd_addr_o     = r_rd_addr;
  assign rd_data_valid = r_rd_valid;

endmodule
`default_nettype wire
